// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state type, requester indices and default widths for the RAM port arbiter
package ram_arb_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int M0 = 0;
    localparam int M1 = 1;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the last winner yields on the next tie
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr;
    always_comb gnt = (&req) ? (ptr ? 2'b10 : 2'b01) : req;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= 1'(M0);
        else if (|gnt) ptr <= gnt[M0];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between two requesters after a post-reset clear sweep
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter int                DATA_W         = DEF_DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        req, gnt, rv;
    logic              clearing;
    // rst_n gating keeps the RAM and clients quiet while reset is held
    assign clearing  = rst_n && state == CLEAR;
    assign init_done = rst_n && state == RUN;
    assign req       = init_done ? {m1_req, m0_req} : 2'b00;
    rr_arb2 u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt)
    );
    assign m0_gnt    = gnt[M0];
    assign m1_gnt    = gnt[M1];
    assign m0_rvalid = rv[M0];
    assign m1_rvalid = rv[M1];
    assign m0_rdata  = ram_q;
    assign m1_rdata  = ram_q;
    always_comb begin
        ram_we   = clearing || (gnt[M0] && m0_we) || (gnt[M1] && m1_we);
        ram_addr = clearing ? cnt : gnt[M0] ? m0_addr : gnt[M1] ? m1_addr : '0;
        ram_data = clearing ? CLEAR_VAL : gnt[M0] ? m0_wdata : gnt[M1] ? m1_wdata : '0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt   <= '0;
            rv    <= '0;
        end else begin
            rv <= gnt & ~{m1_we, m0_we};
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
                if (&cnt) state <= RUN;
            end
        end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: random and directed traffic checked against a rule-level model of the arbiter
module tb_ram_port_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          init_done, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic          req [2], we [2], gnt [2], rvalid [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2], rdata [2];

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
    );

    logic          nc_init_done, nc_req, nc_gnt0, nc_gnt1, nc_rv0, nc_rv1, nc_ram_we;
    logic [AW-1:0] nc_addr, nc_ram_addr;
    logic [DW-1:0] nc_rd0, nc_rd1, nc_ram_data;
    logic [DW-1:0] nc_zero = '0;
    logic          nc_low = 1'b0;
    logic [AW-1:0] nc_azero = '0;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .init_done(nc_init_done),
        .m0_req(nc_req), .m0_we(nc_low), .m0_addr(nc_addr), .m0_wdata(nc_zero),
        .m0_gnt(nc_gnt0), .m0_rvalid(nc_rv0), .m0_rdata(nc_rd0),
        .m1_req(nc_low), .m1_we(nc_low), .m1_addr(nc_azero), .m1_wdata(nc_zero),
        .m1_gnt(nc_gnt1), .m1_rvalid(nc_rv1), .m1_rdata(nc_rd1),
        .ram_we(nc_ram_we), .ram_addr(nc_ram_addr), .ram_data(nc_ram_data), .ram_q(nc_zero)
    );

    // RAM with registered read address and new-data-on-write behaviour
    logic [DW-1:0] ram [N];
    logic [AW-1:0] ram_ra;
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_data;
        ram_ra <= ram_addr;
    end
    assign ram_q = ram[ram_ra];

    int checks = 0;
    int fails  = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // model: clear progress, who was served last, the outstanding read and the memory contents
    int            clr, pend, g;
    logic          last;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] pend_d;
    logic          gs [2];

    always @(negedge clk) begin
        gs[0] = gnt[0];
        gs[1] = gnt[1];
        if (!rst_n) begin
            check("rst_quiet", {init_done, gnt[0], gnt[1], ram_we, rvalid[0], rvalid[1]}, 0);
            clr  = 0;
            last = 1'b1;
            pend = -1;
        end else begin
            check("rv0", rvalid[0], pend == 0);
            check("rv1", rvalid[1], pend == 1);
            if (pend >= 0) check("rdata", rdata[pend], pend_d);
            pend = -1;
            if (clr < N) begin
                check("clr_init", init_done, 0);
                check("clr_gnt", {gnt[0], gnt[1]}, 0);
                check("clr_we", ram_we, 1);
                check("clr_addr", ram_addr, clr);
                check("clr_data", ram_data, 0);
                mem[clr] = '0;
                clr++;
            end else begin
                g = (req[0] && req[1]) ? (last ? 0 : 1) : req[0] ? 0 : req[1] ? 1 : -1;
                check("run_init", init_done, 1);
                check("gnt0", gnt[0], g == 0);
                check("gnt1", gnt[1], g == 1);
                if (g < 0) check("idle_bus", {ram_we, ram_addr, ram_data}, 0);
                else begin
                    check("bus_we", ram_we, we[g]);
                    check("bus_addr", ram_addr, addr[g]);
                    check("bus_data", ram_data, wdata[g]);
                    if (we[g]) mem[addr[g]] = wdata[g];
                    else begin
                        pend   = g;
                        pend_d = mem[addr[g]];
                    end
                    last = (g == 1);
                end
            end
        end
    end

    // entered and left at posedge+1; holds the request until granted
    task automatic access(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        int t = 0;
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        do begin
            @(negedge clk);
            t++;
        end while (!gnt[i] && t < 200);
        check("gnt_wait", gnt[i], 1);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic read_chk(int i, logic [AW-1:0] a, logic [DW-1:0] e, string tag);
        access(i, 1'b0, a, '0);
        @(negedge clk);
        check(tag, rdata[i], e);
        check({tag, "_rv"}, rvalid[i], 1);
        check({tag, "_other_rv"}, rvalid[1-i], 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_phase(int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++)
                if (!req[i] || gs[i]) begin
                    req[i]   = $urandom_range(0, 3) != 0;
                    we[i]    = 1'($urandom_range(0, 1));
                    addr[i]  = AW'($urandom_range(0, 7));
                    wdata[i] = DW'($urandom);
                end
        end
    endtask

    task automatic drain();
        int t = 0;
        do begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) if (gs[i]) req[i] = 1'b0;
            t++;
        end while ((req[0] || req[1]) && t < 200);
        check("drain", req[0] || req[1], 0);
    endtask

    int n, n0, n1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        nc_req = 1'b0; nc_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        rand_phase(300);
        drain();
        read_chk(0, 6'h2A, 8'h00, "rd2a");

        access(0, 1'b1, 6'h10, 8'h5A);
        read_chk(0, 6'h10, 8'h5A, "raw10");

        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 6'h01;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'h02;
        n0 = 0; n1 = 0;
        repeat (6) begin
            @(negedge clk);
            n0 += int'(gnt[0]);
            n1 += int'(gnt[1]);
        end
        check("alt_m0", n0, 3);
        check("alt_m1", n1, 3);
        @(posedge clk); #1;
        req[0] = 1'b0; req[1] = 1'b0;
        @(posedge clk); #1;

        access(1, 1'b1, 6'h3F, 8'hC3);
        read_chk(0, 6'h3F, 8'hC3, "rd3f");
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 6'h05;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'h06;
        @(negedge clk);
        check("ptr_m1", gnt[1], 1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        check("ptr_m0_next", gnt[0], 1);
        @(posedge clk); #1;
        req[0] = 1'b0;

        access(1, 1'b0, 6'h3F, '0);
        rst_n = 1'b0;
        nc_req = 1'b1; nc_addr = 6'h05;
        @(negedge clk);
        check("rst_drop_rv", rvalid[1], 0);
        check("nc_rst_init", nc_init_done, 0);
        check("nc_rst_gnt", nc_gnt0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        @(negedge clk);
        check("nc_init", nc_init_done, 1);
        check("nc_first_gnt", nc_gnt0, 1);
        while (!init_done && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("clr_len", n, N);
        @(posedge clk); #1;
        nc_req = 1'b0;
        read_chk(0, 6'h3F, 8'h00, "cleared3f");
        read_chk(1, 6'h10, 8'h00, "cleared10");

        rand_phase(300);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
